// File: rtl/data_sram_resp_pkg.sv
// Shared constants, read-source select type and lane-merge helper for data_sram_resp.
package data_sram_pkg;

  localparam logic [15:0] MMIO_HI    = 16'h1faf;
  localparam logic [15:0] LED_OFF    = 16'hf000;
  localparam logic [15:0] NUM_OFF    = 16'hf010;
  localparam logic [15:0] TIMER_OFF  = 16'he000;
  localparam logic [15:0] SWITCH_OFF = 16'hf020;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  // Source of the registered read data seen on rdata.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } rsel_e;

  // Replace the byte lanes of old_w whose enable bit is set with new_w.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [LANES-1:0]  wen);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(LANES); i++) begin
      if (wen[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bus between the core and the memory responder.
interface data_sram_resp_if;
  import data_sram_pkg::*;

  logic              data_sram_en;
  logic [LANES-1:0]  data_sram_wen;
  logic [31:0]       data_sram_paddr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_paddr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_paddr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp_bram_be.sv
// Single-port, read-first, byte-enabled synchronous RAM; array is never reset.
module bram_be
  import data_sram_pkg::*;
#(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [LANES-1:0][7:0] mem [WORDS];

  // Read-first access: q captures the old word while enabled lanes are updated.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < int'(LANES); i++) begin
        if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side memory responder: scratchpad RAM plus LED/NUM/TIMER/SWITCH MMIO registers.
module data_sram_resp
  import data_sram_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [15:0] MMIO_HI   = data_sram_pkg::MMIO_HI
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_resp_if.slave   bus,
  input  logic [15:0]       switch,
  output logic [15:0]       led,
  output logic [31:0]       num_data
);

  localparam int unsigned ADDR_W = $clog2(RAM_WORDS);

  logic              acc_c;
  logic              is_mmio_c;
  logic              ram_en_c;
  logic [15:0]       offset_c;
  logic [DATA_W-1:0] mmio_rd_c;
  logic [DATA_W-1:0] ram_q;

  rsel_e             sel_q, sel_d;
  logic [DATA_W-1:0] mmio_q, mmio_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       num_q, num_d;
  logic [31:0]       timer_q, timer_d;
  logic [15:0]       sw_meta, sw_sync;

  // Region decode; accesses during reset never reach the RAM.
  always_comb begin
    offset_c  = bus.data_sram_paddr[15:0];
    is_mmio_c = (bus.data_sram_paddr[31:16] == MMIO_HI);
    acc_c     = resetn & bus.data_sram_en;
    ram_en_c  = acc_c & ~is_mmio_c;
  end

  bram_be #(
    .WORDS  (RAM_WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (bus.data_sram_wen),
    .addr  (bus.data_sram_paddr[ADDR_W+1:2]),
    .wdata (bus.data_sram_wdata),
    .rdata (ram_q)
  );

  // Current (pre-write, pre-increment) value of the addressed MMIO register.
  always_comb begin
    mmio_rd_c = '0;
    unique case (offset_c)
      LED_OFF:    mmio_rd_c = {16'h0, led_q};
      NUM_OFF:    mmio_rd_c = num_q;
      TIMER_OFF:  mmio_rd_c = timer_q;
      SWITCH_OFF: mmio_rd_c = {16'h0, sw_sync};
      default:    mmio_rd_c = '0;
    endcase
  end

  // Next-state for read select, MMIO read capture and the MMIO registers.
  always_comb begin
    sel_d   = sel_q;
    mmio_d  = mmio_q;
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (acc_c) begin
      if (is_mmio_c) begin
        sel_d  = SEL_MMIO;
        mmio_d = mmio_rd_c;
        unique case (offset_c)
          LED_OFF: begin
            led_d[15:8] = bus.data_sram_wen[1] ? bus.data_sram_wdata[15:8] : led_q[15:8];
            led_d[7:0]  = bus.data_sram_wen[0] ? bus.data_sram_wdata[7:0]  : led_q[7:0];
          end
          NUM_OFF:   num_d   = lane_merge(num_q, bus.data_sram_wdata, bus.data_sram_wen);
          TIMER_OFF: timer_d = lane_merge(timer_q + 32'd1, bus.data_sram_wdata, bus.data_sram_wen);
          default: ;
        endcase
      end else begin
        sel_d = SEL_RAM;
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q   <= SEL_ZERO;
      mmio_q  <= '0;
      led_q   <= '0;
      num_q   <= '0;
      timer_q <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sel_q   <= sel_d;
      mmio_q  <= mmio_d;
      led_q   <= led_d;
      num_q   <= num_d;
      timer_q <= timer_d;
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // Read data mux over registered sources; holds because every source holds.
  always_comb begin
    bus.data_sram_rdata = '0;
    unique case (sel_q)
      SEL_RAM:  bus.data_sram_rdata = ram_q;
      SEL_MMIO: bus.data_sram_rdata = mmio_q;
      default:  bus.data_sram_rdata = '0;
    endcase
  end

  assign led      = led_q;
  assign num_data = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp.
module tb_data_sram_resp;
  import data_sram_pkg::*;

  localparam logic [31:0] LED_A   = 32'h1faf_f000;
  localparam logic [31:0] NUM_A   = 32'h1faf_f010;
  localparam logic [31:0] TIMER_A = 32'h1faf_e000;
  localparam logic [31:0] SW_A    = 32'h1faf_f020;
  localparam logic [31:0] UNM_A   = 32'h1faf_f030;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] switch;
  logic [15:0] led;
  logic [31:0] num_data;
  int          n_cmp = 0;
  int          n_err = 0;

  data_sram_resp_if bus ();

  data_sram_resp #(.RAM_WORDS(1024)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus.slave),
    .switch   (switch),
    .led      (led),
    .num_data (num_data)
  );

  always #5 clk = ~clk;

  // Drive one request, clock it in, and settle just after the edge.
  task automatic cyc(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_paddr = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(1'b1, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_err++;
      $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    n_cmp++; if (num_data !== 32'h0) begin n_err++;
      $display("FAIL reset_num got=%h exp=%h", num_data, 32'h0); end
    resetn = 1'b1;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_full_write();
    cyc(1'b1, 4'hf, 32'h0000_0040, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1234_5678) begin n_err++;
      $display("FAIL full_write got=%h exp=%h", bus.data_sram_rdata, 32'h1234_5678); end
  endtask

  task automatic test_byte_lane();
    cyc(1'b1, 4'hf, 32'h0000_0044, 32'h1234_5678);
    cyc(1'b1, 4'b0010, 32'h0000_0044, 32'h0000_ab00);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1234_5678) begin n_err++;
      $display("FAIL read_first got=%h exp=%h", bus.data_sram_rdata, 32'h1234_5678); end
    cyc(1'b1, 4'h0, 32'h0000_0044, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1234_ab78) begin n_err++;
      $display("FAIL byte_lane got=%h exp=%h", bus.data_sram_rdata, 32'h1234_ab78); end
  endtask

  task automatic test_alias_hold();
    cyc(1'b1, 4'hf, 32'h0000_0040, 32'hdead_beef);
    cyc(1'b1, 4'h0, 32'h0000_1040, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'hdead_beef) begin n_err++;
      $display("FAIL alias_1040 got=%h exp=%h", bus.data_sram_rdata, 32'hdead_beef); end
    cyc(1'b1, 4'h0, 32'h7fff_1043, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'hdead_beef) begin n_err++;
      $display("FAIL alias_high got=%h exp=%h", bus.data_sram_rdata, 32'hdead_beef); end
    cyc(1'b0, 4'hf, 32'h0000_0044, 32'h5555_5555);
    cyc(1'b0, 4'h0, 32'h0000_0044, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'hdead_beef) begin n_err++;
      $display("FAIL idle_hold got=%h exp=%h", bus.data_sram_rdata, 32'hdead_beef); end
    cyc(1'b1, 4'h0, 32'h0000_0044, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1234_ab78) begin n_err++;
      $display("FAIL idle_no_write got=%h exp=%h", bus.data_sram_rdata, 32'h1234_ab78); end
  endtask

  task automatic test_timer();
    cyc(1'b1, 4'hf, TIMER_A, 32'hffff_fffe);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, TIMER_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'hffff_ffff) begin n_err++;
      $display("FAIL timer_max got=%h exp=%h", bus.data_sram_rdata, 32'hffff_ffff); end
    cyc(1'b1, 4'h0, TIMER_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL timer_wrap got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    cyc(1'b1, 4'b0001, TIMER_A, 32'h1111_11aa);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1) begin n_err++;
      $display("FAIL timer_wr_old got=%h exp=%h", bus.data_sram_rdata, 32'h1); end
    cyc(1'b1, 4'h0, TIMER_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0000_00aa) begin n_err++;
      $display("FAIL timer_lane got=%h exp=%h", bus.data_sram_rdata, 32'h0000_00aa); end
  endtask

  task automatic test_mmio();
    cyc(1'b1, 4'hf, LED_A, 32'h1234_00ff);
    n_cmp++; if (led !== 16'h00ff) begin n_err++;
      $display("FAIL led_out got=%h exp=%h", led, 16'h00ff); end
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL led_wr_old got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    cyc(1'b1, 4'h0, LED_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0000_00ff) begin n_err++;
      $display("FAIL led_read got=%h exp=%h", bus.data_sram_rdata, 32'h0000_00ff); end
    cyc(1'b1, 4'h0, SW_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0000_a5a5) begin n_err++;
      $display("FAIL switch_read got=%h exp=%h", bus.data_sram_rdata, 32'h0000_a5a5); end
    cyc(1'b1, 4'h0, UNM_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL unmapped_read got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    cyc(1'b1, 4'hf, NUM_A, 32'h8765_4321);
    n_cmp++; if (num_data !== 32'h8765_4321) begin n_err++;
      $display("FAIL num_out got=%h exp=%h", num_data, 32'h8765_4321); end
    cyc(1'b1, 4'hf, SW_A, 32'hffff_ffff);
    cyc(1'b1, 4'h0, SW_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0000_a5a5) begin n_err++;
      $display("FAIL switch_ro got=%h exp=%h", bus.data_sram_rdata, 32'h0000_a5a5); end
    cyc(1'b1, 4'hf, UNM_A, 32'hffff_ffff);
    cyc(1'b1, 4'h0, UNM_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL unmapped_wr got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 4'hf, 32'h0000_0080, 32'h1122_3344);
    cyc(1'b1, 4'h0, 32'h0000_0080, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1122_3344) begin n_err++;
      $display("FAIL pre_reset_rd got=%h exp=%h", bus.data_sram_rdata, 32'h1122_3344); end
    resetn = 1'b0;
    cyc(1'b1, 4'hf, 32'h0000_0080, 32'hffff_ffff);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL mid_reset_rdata got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_err++;
      $display("FAIL mid_reset_led got=%h exp=%h", led, 16'h0); end
    n_cmp++; if (num_data !== 32'h0) begin n_err++;
      $display("FAIL mid_reset_num got=%h exp=%h", num_data, 32'h0); end
    resetn = 1'b1;
    cyc(1'b1, 4'h0, TIMER_A, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h0) begin n_err++;
      $display("FAIL timer_restart got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    cyc(1'b1, 4'h0, 32'h0000_0080, 32'h0);
    n_cmp++; if (bus.data_sram_rdata !== 32'h1122_3344) begin n_err++;
      $display("FAIL ram_kept got=%h exp=%h", bus.data_sram_rdata, 32'h1122_3344); end
  endtask

  initial begin
    resetn              = 1'b0;
    switch              = 16'ha5a5;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'h0;
    bus.data_sram_paddr = 32'h0;
    bus.data_sram_wdata = 32'h0;
    test_reset();
    test_full_write();
    test_byte_lane();
    test_alias_hold();
    test_timer();
    test_mmio();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
